// File: rtl/fp_mul_norm_round_pipe.sv
// Normalise/round back-end for the FP multiplier: S1 aligns the raw significand
// product, S2 rounds, range-checks and packs {sign,exp,frac} with ovf/unf/inx flags.
module fp_mul_norm_round_pipe #(
    parameter int MANT_W = 23,
    parameter int EXP_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*MANT_W+1:0]       in_prod,
    input  logic [EXP_W+1:0]          in_exp,
    input  logic                      in_sign,
    input  logic [1:0]                in_rmode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+MANT_W:0]     out_result,
    output logic                      out_ovf,
    output logic                      out_unf,
    output logic                      out_inx
);
    localparam int N  = 2*MANT_W + 2;
    // One guard bit above the input exponent width so +1 and the rounding carry never wrap.
    localparam int EW = EXP_W + 3;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ZERO = '0;

    // Stage 1 registers
    logic                     s1_valid_reg;
    logic                     s1_sign_reg;
    logic [1:0]               s1_rmode_reg;
    logic [MANT_W-1:0]        s1_frac_reg;
    logic                     s1_g_reg;
    logic                     s1_s_reg;
    logic signed [EW-1:0]     s1_e_reg;
    logic                     s1_zero_reg;

    logic s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid_reg || s2_adv;

    // S1 normalise
    logic [MANT_W-1:0]    norm_frac_next;
    logic                 norm_g_next;
    logic                 norm_s_next;
    logic signed [EW-1:0] in_exp_ext;
    logic signed [EW-1:0] norm_e_next;

    assign in_exp_ext = {in_exp[EXP_W+1], in_exp};

    always_comb begin
        norm_frac_next = in_prod[N-3:MANT_W];
        norm_g_next    = in_prod[MANT_W-1];
        norm_s_next    = |in_prod[MANT_W-2:0];
        norm_e_next    = in_exp_ext;
        if (in_prod[N-1]) begin
            norm_frac_next = in_prod[N-2:MANT_W+1];
            norm_g_next    = in_prod[MANT_W];
            norm_s_next    = |in_prod[MANT_W-1:0];
            norm_e_next    = in_exp_ext + EW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_rmode_reg <= 2'b00;
            s1_frac_reg  <= '0;
            s1_g_reg     <= 1'b0;
            s1_s_reg     <= 1'b0;
            s1_e_reg     <= '0;
            s1_zero_reg  <= 1'b0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_sign_reg  <= in_sign;
                s1_rmode_reg <= in_rmode;
                s1_frac_reg  <= norm_frac_next;
                s1_g_reg     <= norm_g_next;
                s1_s_reg     <= norm_s_next;
                s1_e_reg     <= norm_e_next;
                s1_zero_reg  <= (in_prod == '0);
            end
        end
    end

    // S2 round
    logic                 inc;
    logic                 carry;
    logic [MANT_W-1:0]    frac_r;
    logic signed [EW-1:0] e_r;
    logic                 lost;

    assign lost = s1_g_reg || s1_s_reg;

    always_comb begin
        inc = 1'b0;
        case (s1_rmode_reg)
            RM_RNE: inc = s1_g_reg && (s1_s_reg || s1_frac_reg[0]);
            RM_RTZ: inc = 1'b0;
            RM_RUP: inc = !s1_sign_reg && lost;
            RM_RDN: inc = s1_sign_reg && lost;
            default: inc = 1'b0;
        endcase
    end

    // A carry out of the fraction leaves frac_r all-zero, i.e. 1.0 at the next exponent.
    assign {carry, frac_r} = {1'b0, s1_frac_reg} + (MANT_W+1)'(inc);
    assign e_r             = s1_e_reg + EW'(carry);

    // S2 range check and pack
    logic [EXP_W+MANT_W:0] res_next;
    logic                  ovf_next;
    logic                  unf_next;
    logic                  inx_next;
    logic                  to_inf;

    assign to_inf = (s1_rmode_reg == RM_RNE)
                 || (s1_rmode_reg == RM_RUP && !s1_sign_reg)
                 || (s1_rmode_reg == RM_RDN &&  s1_sign_reg);

    always_comb begin
        res_next = {s1_sign_reg, e_r[EXP_W-1:0], frac_r};
        ovf_next = 1'b0;
        unf_next = 1'b0;
        inx_next = lost;
        if (s1_zero_reg) begin
            res_next = {s1_sign_reg, {(EXP_W+MANT_W){1'b0}}};
            inx_next = 1'b0;
        end else if (e_r >= E_MAX) begin
            ovf_next = 1'b1;
            inx_next = 1'b1;
            if (to_inf)
                res_next = {s1_sign_reg, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            else
                res_next = {s1_sign_reg, {{(EXP_W-1){1'b1}}, 1'b0}, {MANT_W{1'b1}}};
        end else if (e_r <= E_ZERO) begin
            unf_next = 1'b1;
            inx_next = 1'b1;
            res_next = {s1_sign_reg, {(EXP_W+MANT_W){1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_ovf    <= 1'b0;
            out_unf    <= 1'b0;
            out_inx    <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_result <= res_next;
                out_ovf    <= ovf_next;
                out_unf    <= unf_next;
                out_inx    <= inx_next;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_norm_round_pipe.sv
// Scoreboard bench for fp_mul_norm_round_pipe (single precision): the driver queues
// hand-computed results, a negedge monitor pops and compares each accepted output.
module tb_fp_mul_norm_round_pipe;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_prod;
    logic [9:0]  in_exp;
    logic        in_sign;
    logic [1:0]  in_rmode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_unf;
    logic        out_inx;

    fp_mul_norm_round_pipe #(.MANT_W(23), .EXP_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_prod    (in_prod),
        .in_exp     (in_exp),
        .in_sign    (in_sign),
        .in_rmode   (in_rmode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf),
        .out_inx    (out_inx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n_acc = 0;
    int n_out = 0;
    logic [34:0] exp_q[$];

    // Monitor: compares every output transfer and checks a stalled output stays put.
    logic        hold_pending = 1'b0;
    logic [34:0] held;
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                tests++;
                if ({out_ovf, out_unf, out_inx, out_result} !== held) begin
                    fails++;
                    $display("[TB] FAIL hold: got %h required %h",
                             {out_ovf, out_unf, out_inx, out_result}, held);
                end
            end
            hold_pending = out_valid && !out_ready;
            held = {out_ovf, out_unf, out_inx, out_result};
            if (out_valid && out_ready) begin
                logic [34:0] e;
                tests++;
                n_out++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_out: got result=%h flags=%b required none",
                             out_result, {out_ovf, out_unf, out_inx});
                end else begin
                    e = exp_q.pop_front();
                    if ({out_ovf, out_unf, out_inx, out_result} !== e) begin
                        fails++;
                        $display("[TB] FAIL result #%0d: got result=%h flags=%b required result=%h flags=%b",
                                 n_out, out_result, {out_ovf, out_unf, out_inx}, e[31:0], e[34:32]);
                    end else begin
                        $display("[TB] out #%0d result=%h flags=%b ok",
                                 n_out, out_result, {out_ovf, out_unf, out_inx});
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send(input logic [47:0] p, input logic [9:0] e, input logic s,
                        input logic [1:0] rm, input logic [31:0] res, input logic [2:0] fl);
        bit done = 0;
        in_valid = 1'b1;
        in_prod  = p;
        in_exp   = e;
        in_sign  = s;
        in_rmode = rm;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({fl, res});
                n_acc++;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("[TB] FAIL send_timeout: got in_ready=0 required 1 within 50 cycles");
        end
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain_timeout: got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic check1(input string name, input logic got, input logic req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %b required %b", name, got, req);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_exp    = '0;
        in_sign   = 1'b0;
        in_rmode  = 2'b00;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check1("reset_out_valid", out_valid, 1'b0);
        tests++;
        if ({out_ovf, out_unf, out_inx, out_result} !== 35'd0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %h required 0",
                     {out_ovf, out_unf, out_inx, out_result});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check1("reset_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // Directed vectors: {ovf,unf,inx}
        send(48'h900000000000, 10'd127, 1'b0, 2'b00, 32'h40100000, 3'b000);
        send(48'h7FFFFFC00000, 10'd127, 1'b0, 2'b00, 32'h40000000, 3'b001);
        send(48'h7FFFFFC00000, 10'd127, 1'b0, 2'b01, 32'h3FFFFFFF, 3'b001);
        send(48'h800000000000, 10'd254, 1'b0, 2'b00, 32'h7F800000, 3'b101);
        send(48'h800000000000, 10'd254, 1'b0, 2'b01, 32'h7F7FFFFF, 3'b101);
        send(48'h800000000000, 10'd254, 1'b1, 2'b10, 32'hFF7FFFFF, 3'b101);
        send(48'h800000000000, 10'd254, 1'b1, 2'b11, 32'hFF800000, 3'b101);
        send(48'h400000000000, 10'd0,   1'b1, 2'b00, 32'h80000000, 3'b011);
        send(48'h000000000000, 10'd50,  1'b0, 2'b00, 32'h00000000, 3'b000);
        send(48'h400000000001, 10'd127, 1'b0, 2'b10, 32'h3F800001, 3'b001);
        send(48'h400000000001, 10'd127, 1'b0, 2'b11, 32'h3F800000, 3'b001);
        send(48'h400000000001, 10'd127, 1'b1, 2'b11, 32'hBF800001, 3'b001);
        send(48'h400000000000, 10'd254, 1'b0, 2'b00, 32'h7F000000, 3'b000);
        send(48'h400000000000, 10'd1,   1'b0, 2'b00, 32'h00800000, 3'b000);
        send(48'h7FFFFFC00000, 10'd254, 1'b0, 2'b00, 32'h7F800000, 3'b101);
        send(48'h400000000000, 10'h3FB, 1'b0, 2'b00, 32'h00000000, 3'b011);
        send(48'h800000000000, 10'h1FF, 1'b0, 2'b00, 32'h7F800000, 3'b101);
        drain();

        // Back-pressure: downstream stalls for 4 cycles during a 4-beat burst.
        n_acc = 0;
        out_ready = 1'b0;
        fork
            begin
                send(48'h900000000000, 10'd127, 1'b0, 2'b00, 32'h40100000, 3'b000);
                send(48'h400000000001, 10'd127, 1'b0, 2'b10, 32'h3F800001, 3'b001);
                send(48'h400000000000, 10'd254, 1'b0, 2'b00, 32'h7F000000, 3'b000);
                send(48'h400000000000, 10'd1,   1'b0, 2'b00, 32'h00800000, 3'b000);
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                check1("stall_in_ready", in_ready, 1'b0);
                tests++;
                if (n_acc != 2) begin
                    fails++;
                    $display("[TB] FAIL stall_accepted: got %0d required 2", n_acc);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset while two beats are in flight: both are lost, nothing stale follows.
        send(48'h900000000000, 10'd127, 1'b0, 2'b00, 32'h40100000, 3'b000);
        send(48'h800000000000, 10'd127, 1'b0, 2'b00, 32'h40000000, 3'b000);
        rst = 1'b1;
        #1;
        check1("midrst_out_valid", out_valid, 1'b0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check1("midrst_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check1("midrst_no_stale", out_valid, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish required finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
